// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes, FSM
// states, default width and the sign-correction helper.
package mult_div_pkg;

    localparam int LARGURA_PADRAO = 32;
    // One shift-add or restoring step per cycle, one per operand bit.
    localparam int N_ITER         = LARGURA_PADRAO;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        AJUSTA  = 2'd2,
        FIM     = 2'd3
    } estado_t;

    // Conditional two's-complement of one word with an explicit carry-in.
    // A single word is negated with cin = neg; a double word is negated by
    // chaining the carry out of the low word (set only when that word is 0).
    function automatic logic [LARGURA_PADRAO-1:0] corrige_sinal(
        input logic [LARGURA_PADRAO-1:0] v,
        input logic                      neg,
        input logic                      cin
    );
        return (neg ? ~v : v) + {{(LARGURA_PADRAO-1){1'b0}}, cin};
    endfunction

endpackage

// File: rtl/unidade_mult_div.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers. Both algorithms
// run on magnitudes through one shared adder/subtractor; signs are fixed up
// in a single AJUSTA cycle before the result is committed.
module unidade_mult_div
    import mult_div_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         Operacao,
    input  logic [LARGURA-1:0] Valor_Reg1,
    input  logic [LARGURA-1:0] Valor_Reg2,
    input  logic               Escreve_HI,
    input  logic               Escreve_LO,
    input  logic [LARGURA-1:0] Dado_escrita,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [LARGURA-1:0] HI,
    output logic [LARGURA-1:0] LO
);

    localparam int               CW     = $clog2(LARGURA);
    localparam logic [CW-1:0]    ULTIMA = CW'(LARGURA - 1);

    estado_t                  estado_q, estado_d;
    logic [1:0]               op_q, op_d;
    logic [LARGURA-1:0]       b_q, b_d;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier bits being consumed / dividend shifting into quotient.
    logic [2*LARGURA-1:0]     acc_q, acc_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     neg_q, neg_d;     // product / quotient sign
    logic                     negr_q, negr_d;   // remainder sign (follows A)
    logic                     dz_q, dz_d;
    logic [LARGURA-1:0]       hi_q, hi_d, lo_q, lo_d;

    logic                     eh_div;
    logic [LARGURA:0]         resto_desl;
    logic [LARGURA:0]         som_x, som_y, soma;
    logic                     com_sinal;
    logic [LARGURA-1:0]       abs_a, abs_b;
    logic [LARGURA-1:0]       prod_lo, prod_hi, quo, resto;

    assign eh_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Shared datapath: add |B| to the partial product, or trial-subtract |B|
    // from the shifted partial remainder. Since rem < |B|, the shifted value
    // minus |B| is below 2^LARGURA when non-negative, so bit LARGURA of the
    // result is a clean borrow flag.
    assign resto_desl = {acc_q[2*LARGURA-1:LARGURA], acc_q[LARGURA-1]};
    assign som_x      = eh_div ? resto_desl : {1'b0, acc_q[2*LARGURA-1:LARGURA]};
    assign som_y      = {1'b0, b_q};
    assign soma       = som_x + (eh_div ? ~som_y : som_y) + {{LARGURA{1'b0}}, eh_div};

    assign com_sinal = (Operacao == OP_MULT) || (Operacao == OP_DIV);
    assign abs_a     = (com_sinal && Valor_Reg1[LARGURA-1]) ? -Valor_Reg1 : Valor_Reg1;
    assign abs_b     = (com_sinal && Valor_Reg2[LARGURA-1]) ? -Valor_Reg2 : Valor_Reg2;

    // Sign fix-up. The most-negative / -1 quotient wraps back onto itself.
    assign prod_lo = corrige_sinal(acc_q[LARGURA-1:0], neg_q, neg_q);
    assign prod_hi = corrige_sinal(acc_q[2*LARGURA-1:LARGURA], neg_q,
                                   neg_q && (acc_q[LARGURA-1:0] == '0));
    assign quo     = corrige_sinal(acc_q[LARGURA-1:0], neg_q, neg_q);
    assign resto   = corrige_sinal(acc_q[2*LARGURA-1:LARGURA], negr_q, negr_q);

    // Next-state, operand capture, iteration step and HI/LO writes.
    always_comb begin
        estado_d = estado_q;
        op_d     = op_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    op_d   = Operacao;
                    b_d    = abs_b;
                    acc_d  = {{LARGURA{1'b0}}, abs_a};
                    cnt_d  = '0;
                    neg_d  = com_sinal && (Valor_Reg1[LARGURA-1] ^ Valor_Reg2[LARGURA-1]);
                    negr_d = com_sinal && Valor_Reg1[LARGURA-1];
                    dz_d   = Operacao[1] && (Valor_Reg2 == '0);
                    // Divide-by-zero skips the iterations; it passes through
                    // AJUSTA with the write suppressed so done lands one cycle
                    // after acceptance.
                    estado_d = dz_d ? AJUSTA : CALCULA;
                end else begin
                    if (Escreve_HI) hi_d = Dado_escrita;
                    if (Escreve_LO) lo_d = Dado_escrita;
                end
            end
            CALCULA: begin
                if (eh_div)
                    acc_d = {(soma[LARGURA] ? resto_desl[LARGURA-1:0] : soma[LARGURA-1:0]),
                             acc_q[LARGURA-2:0], ~soma[LARGURA]};
                else
                    acc_d = {(acc_q[0] ? soma : {1'b0, acc_q[2*LARGURA-1:LARGURA]}),
                             acc_q[LARGURA-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ULTIMA) estado_d = AJUSTA;
            end
            AJUSTA: begin
                if (!dz_q) begin
                    if (eh_div) begin
                        lo_d = quo;
                        hi_d = resto;
                    end else begin
                        lo_d = prod_lo;
                        hi_d = prod_hi;
                    end
                end
                estado_d = FIM;
            end
            FIM: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    // State registers; synchronous reset has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            op_q     <= OP_MULT;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            estado_q <= estado_d;
            op_q     <= op_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy     = (estado_q != OCIOSO);
    assign done     = (estado_q == FIM);
    assign div_zero = dz_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Bench for unidade_mult_div: directed cases plus random operations checked
// against an arithmetic reference model.
module tb_unidade_mult_div;
    import mult_div_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  Operacao;
    logic [31:0] Valor_Reg1, Valor_Reg2;
    logic        Escreve_HI, Escreve_LO;
    logic [31:0] Dado_escrita;
    logic        busy, done, div_zero;
    logic [31:0] HI, LO;

    int checks   = 0;
    int failures = 0;

    logic [31:0] hi_m = 32'h0;
    logic [31:0] lo_m = 32'h0;
    logic        dz_m = 1'b0;

    unidade_mult_div #(.LARGURA(32)) dut (
        .clk(clk), .rst(rst), .start(start), .Operacao(Operacao),
        .Valor_Reg1(Valor_Reg1), .Valor_Reg2(Valor_Reg2),
        .Escreve_HI(Escreve_HI), .Escreve_LO(Escreve_LO),
        .Dado_escrita(Dado_escrita),
        .busy(busy), .done(done), .div_zero(div_zero), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the architectural values.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        int              q, r;
        dz_m = 1'b0;
        case (op)
            OP_MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi_m = p[63:32]; lo_m = p[31:0];
            end
            OP_MULTU: begin
                pu = {32'h0, a} * {32'h0, b};
                hi_m = pu[63:32]; lo_m = pu[31:0];
            end
            OP_DIV: begin
                if (b == 32'h0) dz_m = 1'b1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000; hi_m = 32'h0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    lo_m = q; hi_m = r;
                end
            end
            default: begin
                if (b == 32'h0) dz_m = 1'b1;
                else begin lo_m = a / b; hi_m = a % b; end
            end
        endcase
    endtask

    // Issue one operation and follow it edge by edge until done + 1.
    // inj: poke start/Escreve_LO while busy; wr: MTHI strobe alongside start.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit inj, input bit wr);
        int done_edge, pulses, exp_edge;
        bit busy_gap;
        logic [31:0] hi_prev;
        hi_prev = hi_m;
        model(op, a, b);
        exp_edge = dz_m ? 1 : 33;
        @(negedge clk);
        start = 1'b1; Operacao = op; Valor_Reg1 = a; Valor_Reg2 = b;
        if (wr) begin Escreve_HI = 1'b1; Dado_escrita = 32'hDEAD_BEEF; end
        @(posedge clk); #1;
        start = 1'b0; Escreve_HI = 1'b0;
        Operacao = 2'($urandom); Valor_Reg1 = $urandom; Valor_Reg2 = $urandom;
        chk({nm, "_busy_at_start"}, busy, 1);
        if (wr) chk({nm, "_hi_write_dropped"}, HI, hi_prev);
        done_edge = -1; pulses = 0; busy_gap = 0;
        for (int k = 1; k <= exp_edge + 1; k++) begin
            @(posedge clk); #1;
            if (done) begin pulses++; if (done_edge < 0) done_edge = k; end
            if (k <= exp_edge && !busy) busy_gap = 1;
            if (inj && k == 9) begin
                start = 1'b1; Operacao = OP_DIVU; Valor_Reg1 = 32'd1; Valor_Reg2 = 32'd1;
                Escreve_LO = 1'b1; Dado_escrita = 32'hAB;
            end
            if (inj && k == 10) begin start = 1'b0; Escreve_LO = 1'b0; end
            if (k == exp_edge) begin
                chk({nm, "_HI"}, HI, hi_m);
                chk({nm, "_LO"}, LO, lo_m);
                chk({nm, "_div_zero"}, div_zero, dz_m);
            end
        end
        chk({nm, "_done_edge"}, done_edge, exp_edge);
        chk({nm, "_done_pulses"}, pulses, 1);
        chk({nm, "_busy_gap"}, busy_gap, 0);
        chk({nm, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int pulses;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; Operacao = 2'b00; Valor_Reg1 = '0; Valor_Reg2 = '0;
        Escreve_HI = 1'b0; Escreve_LO = 1'b0; Dado_escrita = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_HI", HI, 0); chk("rst_LO", LO, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_div_zero", div_zero, 0);
        @(negedge clk); rst = 1'b0;

        // Both strobes together write both registers.
        Escreve_HI = 1'b1; Escreve_LO = 1'b1; Dado_escrita = 32'h5A;
        @(posedge clk); #1; Escreve_HI = 1'b0; Escreve_LO = 1'b0;
        chk("mt_both_HI", HI, 32'h5A); chk("mt_both_LO", LO, 32'h5A);
        @(negedge clk); Escreve_HI = 1'b1; Dado_escrita = 32'h11;
        @(posedge clk); #1; Escreve_HI = 1'b0;
        chk("mthi_HI", HI, 32'h11); chk("mthi_LO_kept", LO, 32'h5A);
        @(negedge clk); Escreve_LO = 1'b1; Dado_escrita = 32'h22;
        @(posedge clk); #1; Escreve_LO = 1'b0;
        chk("mtlo_LO", LO, 32'h22); chk("mtlo_HI_kept", HI, 32'h11);
        hi_m = 32'h11; lo_m = 32'h22;

        run_op("divu_by0", OP_DIVU, 32'd25, 32'd0, 0, 0);
        chk("divu_by0_HI_const", HI, 32'h11); chk("divu_by0_LO_const", LO, 32'h22);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("multu_max_HI_const", HI, 32'hFFFF_FFFE); chk("multu_max_LO_const", LO, 32'h1);
        chk("div_zero_cleared", div_zero, 0);
        run_op("mult_neg", OP_MULT, -32'sd5, 32'd3, 0, 0);
        chk("mult_neg_LO_const", LO, 32'hFFFF_FFF1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("div_ovf_LO_const", LO, 32'h8000_0000); chk("div_ovf_HI_const", HI, 32'h0);
        run_op("div_neg", OP_DIV, -32'sd7, 32'd2, 0, 0);
        chk("div_neg_LO_const", LO, 32'hFFFF_FFFD); chk("div_neg_HI_const", HI, 32'hFFFF_FFFF);
        run_op("divu_25_4", OP_DIVU, 32'd25, 32'd4, 0, 0);
        chk("divu_25_4_LO_const", LO, 32'd6); chk("divu_25_4_HI_const", HI, 32'd1);
        run_op("div_by0", OP_DIV, 32'd9, 32'd0, 0, 0);
        run_op("start_wins", OP_MULTU, 32'd2, 32'd3, 0, 1);
        run_op("busy_ignore", OP_MULTU, 32'd7, 32'd9, 1, 0);
        chk("busy_ignore_LO_const", LO, 32'd63); chk("busy_ignore_HI_const", HI, 32'd0);

        // Reset in the middle of a MULT: no done, everything back to reset values.
        @(negedge clk);
        start = 1'b1; Operacao = OP_MULT; Valor_Reg1 = 32'h1234_5678; Valor_Reg2 = 32'hFFFF_0003;
        @(posedge clk); #1; start = 1'b0;
        pulses = 0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_HI", HI, 0); chk("midrst_LO", LO, 0); chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0); chk("midrst_div_zero", div_zero, 0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        hi_m = 32'h0; lo_m = 32'h0; dz_m = 1'b0;
        run_op("after_rst", OP_MULTU, 32'd2, 32'd3, 0, 0);
        chk("after_rst_LO_const", LO, 32'd6);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'($urandom_range(0, 2));
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 50));
                default: rb = $urandom;
            endcase
            run_op("rand", rop, ra, rb, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
